// File: rtl/alu_seq.sv
// ALU sequencer: owns accumulator A and status P, issues commands to the ALU and writes results back.
// Optional one-entry command queue when ALU_OPQ_EN is defined.
module alu_seq #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned NUM_OPS = 12,
    parameter int unsigned CMP_OP  = 11
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_opnd,
    input  logic       ld_a,
    input  logic       ld_p,
    input  logic [7:0] ld_data,
    output logic [3:0] alu_op,
    output logic [7:0] alu_acc,
    output logic [7:0] alu_opnd,
    output logic [7:0] alu_status,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_status_in,
    output logic [7:0] a_reg,
    output logic [7:0] p_reg,
    output logic       done,
    output logic       err
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      a_q, a_d, p_q, p_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DW-1:0]      acc_q, acc_d, opnd_q, opnd_d, st_q, st_d;
    logic               done_q, done_d, err_q, err_d;

    logic               accept, wb;
    logic [DW-1:0]      a_wb;
    logic               iss;
    logic [OP_W-1:0]    iss_op;
    logic [DW-1:0]      iss_opnd, iss_acc, iss_st;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return 32'(op) < NUM_OPS;
    endfunction

`ifdef ALU_OPQ_EN
    logic               q_valid_q, q_valid_d;
    logic [OP_W-1:0]    q_op_q, q_op_d;
    logic [DW-1:0]      q_opnd_q, q_opnd_d;
    logic               nxt_v;
    logic [OP_W-1:0]    nxt_op;
    logic [DW-1:0]      nxt_opnd;

    assign cmd_ready = ~q_valid_q & ~ld_a & ~ld_p;
`else
    assign cmd_ready = (state_q == IDLE) & ~ld_a & ~ld_p;
`endif

    assign accept = cmd_valid & cmd_ready;
    assign wb     = (state_q == EXEC) && (cnt_q == CNT_W'(1));
    // CMP only updates status; A keeps its old value
    assign a_wb   = (op_q == OP_W'(CMP_OP)) ? a_q : alu_result;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        p_d      = p_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        st_d     = st_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        iss      = 1'b0;
        iss_op   = cmd_op;
        iss_opnd = cmd_opnd;
        iss_acc  = a_q;
        iss_st   = p_q;
`ifdef ALU_OPQ_EN
        q_valid_d = q_valid_q;
        q_op_d    = q_op_q;
        q_opnd_d  = q_opnd_q;
        nxt_v     = q_valid_q | accept;
        nxt_op    = q_valid_q ? q_op_q : cmd_op;
        nxt_opnd  = q_valid_q ? q_opnd_q : cmd_opnd;
`endif
        case (state_q)
            IDLE: begin
                if (ld_a) a_d = ld_data;
                if (ld_p) p_d = ld_data;
                if (accept) begin
                    if (op_legal(cmd_op)) iss = 1'b1;
                    else                  err_d = 1'b1;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (wb) begin
                    a_d     = a_wb;
                    p_d     = alu_status_in;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef ALU_OPQ_EN
                    // Chain the next command straight off the fresh writeback values
                    q_valid_d = 1'b0;
                    if (nxt_v) begin
                        iss_op   = nxt_op;
                        iss_opnd = nxt_opnd;
                        iss_acc  = a_wb;
                        iss_st   = alu_status_in;
                        if (op_legal(nxt_op)) iss = 1'b1;
                        else                  err_d = 1'b1;
                    end
                end else if (accept) begin
                    q_valid_d = 1'b1;
                    q_op_d    = cmd_op;
                    q_opnd_d  = cmd_opnd;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (iss) begin
            op_d    = iss_op;
            opnd_d  = iss_opnd;
            acc_d   = iss_acc;
            st_d    = iss_st;
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk_2 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            st_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            st_q    <= st_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_OPQ_EN
    always_ff @(posedge clk_2 or negedge rst) begin
        if (!rst) begin
            q_valid_q <= 1'b0;
            q_op_q    <= '0;
            q_opnd_q  <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_op_q    <= q_op_d;
            q_opnd_q  <= q_opnd_d;
        end
    end
`endif

    assign alu_op     = op_q;
    assign alu_acc    = acc_q;
    assign alu_opnd   = opnd_q;
    assign alu_status = st_q;
    assign a_reg      = a_q;
    assign p_reg      = p_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_seq;
    localparam int LAT  = 1;
    localparam int NOPS = 12;
    localparam int CMP  = 11;
`ifdef ALU_OPQ_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // main DUT (latency 1)
    logic       rst, cmd_valid, cmd_ready, ld_a, ld_p, done, err;
    logic [3:0] cmd_op, alu_op;
    logic [7:0] cmd_opnd, ld_data, alu_acc, alu_opnd, alu_status, alu_result, alu_status_in, a_reg, p_reg;

    alu_seq #(.ALU_LAT(LAT), .NUM_OPS(NOPS), .CMP_OP(CMP)) u_dut (
        .clk_2(clk_2), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_opnd(cmd_opnd), .ld_a(ld_a), .ld_p(ld_p), .ld_data(ld_data),
        .alu_op(alu_op), .alu_acc(alu_acc), .alu_opnd(alu_opnd), .alu_status(alu_status),
        .alu_result(alu_result), .alu_status_in(alu_status_in),
        .a_reg(a_reg), .p_reg(p_reg), .done(done), .err(err)
    );

    // second DUT (latency 3) for latency and reset-abort scenarios
    logic       rst3, v3, rdy3, done3, err3;
    logic [3:0] op3, aop3;
    logic [7:0] opnd3, acc3, aopnd3, ast3, res3, sts3, a3, p3;

    alu_seq #(.ALU_LAT(3), .NUM_OPS(NOPS), .CMP_OP(CMP)) u_dut3 (
        .clk_2(clk_2), .rst(rst3), .cmd_valid(v3), .cmd_ready(rdy3),
        .cmd_op(op3), .cmd_opnd(opnd3), .ld_a(1'b0), .ld_p(1'b0), .ld_data(8'h00),
        .alu_op(aop3), .alu_acc(acc3), .alu_opnd(aopnd3), .alu_status(ast3),
        .alu_result(res3), .alu_status_in(sts3),
        .a_reg(a3), .p_reg(p3), .done(done3), .err(err3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit [3:0] op; bit [7:0] opnd; } cmd_t;
    cmd_t     mq[$];
    bit [7:0] m_a, m_p, m_acc, m_opnd, m_st;
    bit [3:0] m_op;
    bit       m_busy, m_done, m_err;
    int       m_left;

    function automatic bit exp_ready(input bit la, input bit lp);
        if (la || lp) return 1'b0;
        return QEN ? (mq.size() == 0) : !m_busy;
    endfunction

    function automatic void m_issue(input bit [3:0] op, input bit [7:0] opnd,
                                    input bit [7:0] acc, input bit [7:0] st);
        if (int'(op) >= NOPS) m_err = 1'b1;
        else begin
            m_op = op; m_opnd = opnd; m_acc = acc; m_st = st;
            m_busy = 1'b1; m_left = LAT;
        end
    endfunction

    function automatic void model_step(input bit la, input bit lp, input bit [7:0] ld,
                                       input bit v, input bit [3:0] op, input bit [7:0] opnd,
                                       input bit [7:0] res, input bit [7:0] sts);
        bit   acc;
        cmd_t c;
        acc    = v && exp_ready(la, lp);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_busy) begin
            if (la) m_a = ld;
            if (lp) m_p = ld;
            if (acc) m_issue(op, opnd, m_a, m_p);
        end else begin
            m_left--;
            if (acc) begin c.op = op; c.opnd = opnd; mq.push_back(c); end
            if (m_left == 0) begin
                if (int'(m_op) != CMP) m_a = res;
                m_p    = sts;
                m_done = 1'b1;
                m_busy = 1'b0;
                if (mq.size() > 0) begin
                    c = mq.pop_front();
                    m_issue(c.op, c.opnd, m_a, m_p);
                end
            end
        end
    endfunction

    // one clock of stimulus on the main DUT, checked against the model
    task automatic cycle(input bit la, input bit lp, input bit [7:0] ld, input bit v,
                         input bit [3:0] op, input bit [7:0] opnd,
                         input bit [7:0] res, input bit [7:0] sts);
        @(negedge clk_2);
        ld_a = la; ld_p = lp; ld_data = ld; cmd_valid = v; cmd_op = op; cmd_opnd = opnd;
        alu_result = res; alu_status_in = sts;
        #1 check_eq("cmd_ready", 32'(cmd_ready), 32'(exp_ready(la, lp)));
        @(posedge clk_2);
        #1;
        model_step(la, lp, ld, v, op, opnd, res, sts);
        check_eq("a_reg", 32'(a_reg), 32'(m_a));
        check_eq("p_reg", 32'(p_reg), 32'(m_p));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("alu_op", 32'(alu_op), 32'(m_op));
        check_eq("alu_acc", 32'(alu_acc), 32'(m_acc));
        check_eq("alu_opnd", 32'(alu_opnd), 32'(m_opnd));
        check_eq("alu_status", 32'(alu_status), 32'(m_st));
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_opnd = '0; ld_a = 1'b0; ld_p = 1'b0;
        ld_data = '0; alu_result = '0; alu_status_in = '0;
        rst3 = 1'b0; v3 = 1'b0; op3 = '0; opnd3 = '0; res3 = '0; sts3 = '0;
        m_a = '0; m_p = '0; m_op = '0; m_acc = '0; m_opnd = '0; m_st = '0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_left = 0;

        #12;
        check_eq("rst_a_reg", 32'(a_reg), 32'h0);
        check_eq("rst_p_reg", 32'(p_reg), 32'h0);
        check_eq("rst_alu_op", 32'(alu_op), 32'h0);
        check_eq("rst_alu_acc", 32'(alu_acc), 32'h0);
        check_eq("rst_done_err", 32'({done, err}), 32'h0);
        @(negedge clk_2) rst = 1'b1;
        #1 check_eq("ready_after_rst", 32'(cmd_ready), 32'h1);

        // directed walk-through
        cycle(1, 0, 8'd66, 0, 4'd0, 8'd0, 8'd0, 8'd0);
        check_eq("ld_a_66", 32'(a_reg), 32'd66);
        cycle(0, 1, 8'h00, 0, 4'd0, 8'd0, 8'd0, 8'd0);
        cycle(0, 0, 8'd0, 1, 4'd0, 8'd30, 8'd0, 8'd0);
        check_eq("e0_acc", 32'(alu_acc), 32'd66);
        check_eq("e0_opnd", 32'(alu_opnd), 32'd30);
        cycle(0, 0, 8'd0, 0, 4'd0, 8'd0, 8'd96, 8'h00);
        check_eq("wb_a_96", 32'(a_reg), 32'd96);
        check_eq("wb_done", 32'(done), 32'h1);
        cycle(0, 0, 8'd0, 1, 4'd11, 8'd5, 8'd0, 8'd0);
        cycle(0, 0, 8'd0, 0, 4'd0, 8'd0, 8'h24, 8'h03);
        check_eq("cmp_p", 32'(p_reg), 32'h03);
        check_eq("cmp_a_kept", 32'(a_reg), 32'd96);
        cycle(0, 0, 8'd0, 1, 4'd13, 8'd9, 8'd0, 8'd0);
        check_eq("illegal_err", 32'(err), 32'h1);
        check_eq("illegal_op_kept", 32'(alu_op), 32'd11);
        cycle(0, 0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 8'd0);
        check_eq("err_one_cycle", 32'(err), 32'h0);
`ifdef ALU_OPQ_EN
        cycle(1, 0, 8'd66, 0, 4'd0, 8'd0, 8'd0, 8'd0);
        cycle(0, 0, 8'd0, 1, 4'd0, 8'd30, 8'd0, 8'd0);
        cycle(0, 0, 8'd0, 1, 4'd2, 8'h0F, 8'd96, 8'h00);
        check_eq("q_chain_acc", 32'(alu_acc), 32'd96);
        check_eq("q_chain_op", 32'(alu_op), 32'd2);
        check_eq("q_chain_done1", 32'(done), 32'h1);
        cycle(0, 0, 8'd0, 0, 4'd0, 8'd0, 8'd7, 8'h01);
        check_eq("q_chain_done2", 32'(done), 32'h1);
`endif

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit la, lp, v;
            la = ($urandom % 10) == 0;
            lp = ($urandom % 10) == 0;
            v  = ($urandom % 10) < 6;
            cycle(la, lp, 8'($urandom), v, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // latency-3 DUT: full op timing
        @(negedge clk_2);
        rst3 = 1'b1; v3 = 1'b1; op3 = 4'd0; opnd3 = 8'd5;
        @(posedge clk_2); #1;
        check_eq("l3_e0_opnd", 32'(aopnd3), 32'd5);
        @(negedge clk_2); v3 = 1'b0; res3 = 8'hA5; sts3 = 8'h5A;
        #1 check_eq("l3_ready_exec", 32'(rdy3), 32'(QEN));
        @(posedge clk_2); #1 check_eq("l3_done_e1", 32'(done3), 32'h0);
        @(posedge clk_2); #1 check_eq("l3_done_e2", 32'(done3), 32'h0);
        @(posedge clk_2); #1 check_eq("l3_done_e3", 32'(done3), 32'h1);
        check_eq("l3_a_wb", 32'(a3), 32'hA5);
        check_eq("l3_p_wb", 32'(p3), 32'h5A);
        @(negedge clk_2);
        check_eq("l3_ready_wb", 32'(rdy3), 32'h1);

        // reset two cycles into an op aborts it
        v3 = 1'b1; op3 = 4'd1; opnd3 = 8'd7;
        @(posedge clk_2); #1 check_eq("l3_abort_issue", 32'(aop3), 32'd1);
        @(negedge clk_2); v3 = 1'b0;
        @(posedge clk_2);
        @(posedge clk_2); #1 rst3 = 1'b0;
        #1;
        check_eq("abort_a", 32'(a3), 32'h0);
        check_eq("abort_p", 32'(p3), 32'h0);
        check_eq("abort_alu", 32'({aop3, acc3, aopnd3, ast3}), 32'h0);
        check_eq("abort_done_err", 32'({done3, err3}), 32'h0);
        @(negedge clk_2) rst3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_2); #1;
            check_eq("abort_no_done", 32'(done3), 32'h0);
            check_eq("abort_ready", 32'(rdy3), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
